alu_a_operand_ctrl: RTL and testbench

The ALU operand-A controller sits beside the E-stage operand-A mux of the 5-stage pipeline. It tracks destination registers for the E, M and W stages and drives three things: the forwarding select for the RS operand (MFRSE), the shift-amount select for operand A (MUX_ALU_Asel), and the D-stage stall and E-stage bubble. Stalls come from load-use hazards and from the multi-cycle mult/div unit.

---
 rtl/alu_a_operand_ctrl_pkg.sv | 28 ++
 rtl/muldiv_busy_cnt.sv | 46 ++++
 rtl/alu_a_operand_ctrl.sv | 111 +++++++++++
 tb/tb_alu_a_operand_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_a_operand_ctrl_pkg.sv
// Shared types and constants for the E-stage operand-A controller:
// forward-select encodings, the per-stage pipeline record and default latencies.
package alu_a_operand_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic       uses_rs;
        logic       shift_imm;
        logic       wr_en;
        logic [4:0] wr_reg;
        logic       is_load;
    } stage_rec_t;

    // A later stage can supply a forwarded RS value if it writes that register.
    // Load results are only usable once they have reached W.
    function automatic logic is_fwd_src(stage_rec_t r, logic [4:0] src, logic allow_load);
        return r.valid & r.wr_en & (allow_load | ~r.is_load) & (r.wr_reg == src);
    endfunction

endpackage

// File: rtl/muldiv_busy_cnt.sv
// Busy counter for the multi-cycle mult/div unit: loads the op latency when a
// mult/div enters E, then counts down to zero; busy while nonzero.
module muldiv_busy_cnt
    import alu_a_operand_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_mult,
    input  logic start_div,
    output logic busy
);

    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (start_div) begin
            cnt_d = DIV_CNT;
        end else if (start_mult) begin
            cnt_d = MULT_CNT;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/alu_a_operand_ctrl.sv
// E-stage operand-A controller: tracks E/M/W destination records, selects the
// RS forward source and shamt mux, and raises D-stall / E-bubble on hazards.
module alu_a_operand_ctrl
    import alu_a_operand_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       d_valid,
    input  logic [4:0] d_rs,
    input  logic       d_uses_rs,
    input  logic       d_shift_imm,
    input  logic       d_wr_en,
    input  logic [4:0] d_wr_reg,
    input  logic       d_is_load,
    input  logic       d_is_mult,
    input  logic       d_is_div,
    input  logic       d_uses_hilo,
    output logic       stall_d,
    output logic       flush_e,
    output logic       mux_alu_asel,
    output logic [1:0] mfrse_sel,
    output logic       muldiv_busy
);

    stage_rec_t d_rec;
    stage_rec_t e_d, m_d, w_d;
    stage_rec_t e_q, m_q, w_q;

    logic load_use_haz;
    logic muldiv_haz;
    logic hazard;
    logic start_mult;
    logic start_div;

    always_comb begin
        d_rec = '0;
        if (d_valid) begin
            d_rec.valid     = 1'b1;
            d_rec.rs        = d_rs;
            d_rec.uses_rs   = d_uses_rs;
            d_rec.shift_imm = d_shift_imm;
            d_rec.wr_en     = d_wr_en;
            d_rec.wr_reg    = d_wr_reg;
            d_rec.is_load   = d_is_load;
        end
    end

    // A shift-immediate takes shamt as operand A, so a pending load to its RS is harmless.
    always_comb begin
        load_use_haz = d_valid & d_uses_rs & ~d_shift_imm
                     & e_q.valid & e_q.is_load & e_q.wr_en
                     & (e_q.wr_reg == d_rs) & (d_rs != 5'd0);
        muldiv_haz   = d_valid & muldiv_busy & (d_is_mult | d_is_div | d_uses_hilo);
        hazard       = load_use_haz | muldiv_haz;
    end

    assign stall_d = hazard;
    assign flush_e = hazard;

    assign start_mult = d_valid & d_is_mult & ~hazard;
    assign start_div  = d_valid & d_is_div  & ~hazard;

    always_comb begin
        e_d = hazard ? stage_rec_t'('0) : d_rec;
        m_d = e_q;
        w_d = m_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    // M beats W because it holds the younger write to the same register.
    always_comb begin
        mux_alu_asel = e_q.valid & e_q.shift_imm;
        mfrse_sel    = FWD_RF;
        if (!mux_alu_asel && e_q.uses_rs && (e_q.rs != 5'd0)) begin
            if (is_fwd_src(m_q, e_q.rs, 1'b0)) begin
                mfrse_sel = FWD_M;
            end else if (is_fwd_src(w_q, e_q.rs, 1'b1)) begin
                mfrse_sel = FWD_W;
            end
        end
    end

    logic unused_rec_bits;
    assign unused_rec_bits = ^{w_q.rs, w_q.uses_rs, w_q.shift_imm};

    muldiv_busy_cnt #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_busy_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_mult (start_mult),
        .start_div  (start_div),
        .busy       (muldiv_busy)
    );

endmodule

// File: tb/tb_alu_a_operand_ctrl.sv
// Bench for alu_a_operand_ctrl: directed vector table, mult/div and reset
// sequences, then random instruction streams against a history-based model.
module tb_alu_a_operand_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int HIST_N   = 4096;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic       urs;
        logic       sh;
        logic       we;
        logic [4:0] wr;
        logic       ld;
        logic       mul;
        logic       dv;
        logic       hilo;
    } din_t;

    typedef struct packed {
        logic       st;
        logic       fl;
        logic       as;
        logic [1:0] sel;
        logic       bz;
    } obs_t;

    typedef struct packed {
        din_t       d;
        logic       st;
        logic       as;
        logic [1:0] sel;
    } vec_t;

    logic       clk;
    logic       rst_n;
    din_t       d_in;
    logic       stall_d;
    logic       flush_e;
    logic       mux_alu_asel;
    logic [1:0] mfrse_sel;
    logic       muldiv_busy;

    int   checks;
    int   errors;
    int   cyc;
    int   last_busy;
    din_t hist [0:HIST_N-1];
    vec_t tbl  [0:21];

    alu_a_operand_ctrl #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .d_valid      (d_in.v),
        .d_rs         (d_in.rs),
        .d_uses_rs    (d_in.urs),
        .d_shift_imm  (d_in.sh),
        .d_wr_en      (d_in.we),
        .d_wr_reg     (d_in.wr),
        .d_is_load    (d_in.ld),
        .d_is_mult    (d_in.mul),
        .d_is_div     (d_in.dv),
        .d_uses_hilo  (d_in.hilo),
        .stall_d      (stall_d),
        .flush_e      (flush_e),
        .mux_alu_asel (mux_alu_asel),
        .mfrse_sel    (mfrse_sel),
        .muldiv_busy  (muldiv_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic din_t mk_alu(input logic [4:0] rd, input logic [4:0] rs);
        din_t r = '0;
        r.v = 1'b1; r.rs = rs; r.urs = 1'b1; r.we = 1'b1; r.wr = rd;
        return r;
    endfunction

    function automatic din_t mk_lw(input logic [4:0] rd, input logic [4:0] rs);
        din_t r = mk_alu(rd, rs);
        r.ld = 1'b1;
        return r;
    endfunction

    function automatic din_t mk_sll(input logic [4:0] rd, input logic [4:0] rs);
        din_t r = mk_alu(rd, rs);
        r.sh = 1'b1;
        return r;
    endfunction

    function automatic din_t mk_md(input logic is_div);
        din_t r = '0;
        r.v = 1'b1; r.rs = 5'd1; r.urs = 1'b1;
        r.dv = is_div; r.mul = ~is_div;
        return r;
    endfunction

    function automatic din_t mk_hilo(input logic urs, input logic [4:0] rs, input logic [4:0] rd);
        din_t r = '0;
        r.v = 1'b1; r.urs = urs; r.rs = rs; r.we = 1'b1; r.wr = rd; r.hilo = 1'b1;
        return r;
    endfunction

    function automatic din_t rand_instr();
        int          k;
        logic [4:0]  a;
        logic [4:0]  b;
        k = $urandom_range(0, 9);
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        case (k)
            0, 1, 2, 3: return mk_alu(a, b);
            4, 5:       return mk_lw(a, b);
            6:          return mk_sll(a, b);
            7:          return din_t'('0);
            8:          return mk_md(1'($urandom_range(0, 1)));
            default:    return mk_hilo(1'($urandom_range(0, 1)), b, a);
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic din_t rec_at(input int idx);
        if (idx < 0 || idx >= HIST_N) return din_t'('0);
        return hist[idx];
    endfunction

    // Entry: posedge+1. Drives D, checks the model at the falling edge,
    // then records what entered E at the rising edge.
    task automatic step(input din_t d, output obs_t o);
        din_t       e, m, w;
        logic       lu, md, exp_st, exp_as, exp_bz;
        logic [1:0] exp_sel;
        d_in = d;
        #4;
        e = rec_at(cyc - 1);
        m = rec_at(cyc - 2);
        w = rec_at(cyc - 3);
        exp_bz  = (cyc <= last_busy);
        lu      = d.v && d.urs && !d.sh && e.v && e.ld && e.we && (e.wr == d.rs) && (d.rs != 0);
        md      = d.v && exp_bz && (d.mul || d.dv || d.hilo);
        exp_st  = lu || md;
        exp_as  = e.v && e.sh;
        exp_sel = 2'd0;
        if (!exp_as && e.urs && e.rs != 0) begin
            if (m.v && m.we && !m.ld && m.wr == e.rs) exp_sel = 2'd1;
            else if (w.v && w.we && w.wr == e.rs)      exp_sel = 2'd2;
        end
        chk("stall_d", stall_d, exp_st);
        chk("flush_e", flush_e, exp_st);
        chk("mux_alu_asel", mux_alu_asel, exp_as);
        chk("mfrse_sel", mfrse_sel, exp_sel);
        chk("muldiv_busy", muldiv_busy, exp_bz);
        o.st = stall_d; o.fl = flush_e; o.as = mux_alu_asel; o.sel = mfrse_sel; o.bz = muldiv_busy;
        @(posedge clk);
        if (cyc < HIST_N) hist[cyc] = (d.v && !exp_st) ? d : din_t'('0);
        if (d.v && !exp_st && (d.dv || d.mul)) last_busy = cyc + (d.dv ? DIV_LAT : MULT_LAT);
        cyc++;
        #1;
    endtask

    task automatic run_md(input logic is_div, input int lat);
        obs_t o;
        int   n;
        logic done;
        n = 0;
        done = 1'b0;
        step(mk_md(is_div), o);
        for (int k = 0; k < 40 && !done; k++) begin
            step(mk_hilo(1'b0, 5'd0, 5'd6), o);
            if (o.st) begin
                n++;
                chk("busy_while_stalled", o.bz, 1);
            end else begin
                done = 1'b1;
                chk("busy_at_release", o.bz, 0);
            end
        end
        chk(is_div ? "div_stall_len" : "mult_stall_len", n, lat);
    endtask

    initial begin
        obs_t o;
        din_t cur;
        int   n;
        logic done;

        checks = 0; errors = 0; cyc = 0; last_busy = -1;
        for (int i = 0; i < HIST_N; i++) hist[i] = '0;
        rst_n = 1'b0;
        d_in  = '0;

        tbl[0]  = '{mk_alu(3, 1),   1'b0, 1'b0, 2'd0};
        tbl[1]  = '{mk_alu(4, 3),   1'b0, 1'b0, 2'd0};
        tbl[2]  = '{din_t'('0),     1'b0, 1'b0, 2'd1};
        tbl[3]  = '{mk_alu(5, 7),   1'b0, 1'b0, 2'd0};
        tbl[4]  = '{mk_alu(9, 1),   1'b0, 1'b0, 2'd0};
        tbl[5]  = '{mk_alu(8, 5),   1'b0, 1'b0, 2'd0};
        tbl[6]  = '{din_t'('0),     1'b0, 1'b0, 2'd2};
        tbl[7]  = '{din_t'('0),     1'b0, 1'b0, 2'd0};
        tbl[8]  = '{mk_lw(5, 0),    1'b0, 1'b0, 2'd0};
        tbl[9]  = '{mk_alu(10, 5),  1'b1, 1'b0, 2'd0};
        tbl[10] = '{mk_alu(10, 5),  1'b0, 1'b0, 2'd0};
        tbl[11] = '{din_t'('0),     1'b0, 1'b0, 2'd2};
        tbl[12] = '{mk_lw(0, 1),    1'b0, 1'b0, 2'd0};
        tbl[13] = '{mk_alu(11, 0),  1'b0, 1'b0, 2'd0};
        tbl[14] = '{din_t'('0),     1'b0, 1'b0, 2'd0};
        tbl[15] = '{mk_lw(5, 2),    1'b0, 1'b0, 2'd0};
        tbl[16] = '{mk_sll(12, 5),  1'b0, 1'b0, 2'd0};
        tbl[17] = '{din_t'('0),     1'b0, 1'b1, 2'd0};
        tbl[18] = '{mk_alu(5, 1),   1'b0, 1'b0, 2'd0};
        tbl[19] = '{mk_sll(12, 5),  1'b0, 1'b0, 2'd0};
        tbl[20] = '{din_t'('0),     1'b0, 1'b1, 2'd0};
        tbl[21] = '{din_t'('0),     1'b0, 1'b0, 2'd0};

        #12;
        chk("rst_stall_d", stall_d, 0);
        chk("rst_flush_e", flush_e, 0);
        chk("rst_asel", mux_alu_asel, 0);
        chk("rst_sel", mfrse_sel, 0);
        chk("rst_busy", muldiv_busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1;

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].d, o);
            chk($sformatf("tbl%0d_stall", i), o.st, tbl[i].st);
            chk($sformatf("tbl%0d_flush", i), o.fl, tbl[i].st);
            chk($sformatf("tbl%0d_asel", i), o.as, tbl[i].as);
            chk($sformatf("tbl%0d_sel", i), o.sel, tbl[i].sel);
            chk($sformatf("tbl%0d_busy", i), o.bz, 0);
        end

        run_md(1'b1, DIV_LAT);
        run_md(1'b0, MULT_LAT);

        // lw $2 reaches E while the div counter reads 4; mflo reading $2 waits in D.
        step(mk_md(1'b1), o);
        repeat (5) step(din_t'('0), o);
        step(mk_lw(2, 1), o);
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            step(mk_hilo(1'b1, 5'd2, 5'd7), o);
            if (o.st) begin
                n++;
                chk("ovl_flush", o.fl, 1);
            end else begin
                done = 1'b1;
            end
        end
        chk("ovl_stall_len", n, 4);
        repeat (3) step(din_t'('0), o);

        // Reset in the middle of a mult count with a hilo reader stalled in D.
        step(mk_md(1'b0), o);
        step(mk_alu(1, 2), o);
        step(din_t'('0), o);
        d_in = mk_hilo(1'b0, 5'd0, 5'd6);
        #2;
        chk("pre_rst_stall", stall_d, 1);
        chk("pre_rst_busy", muldiv_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall_d", stall_d, 0);
        chk("mid_rst_flush_e", flush_e, 0);
        chk("mid_rst_asel", mux_alu_asel, 0);
        chk("mid_rst_sel", mfrse_sel, 0);
        chk("mid_rst_busy", muldiv_busy, 0);
        d_in = mk_alu(4, 1);
        @(posedge clk);
        #2;
        chk("held_rst_busy", muldiv_busy, 0);
        rst_n = 1'b1;
        for (int i = 0; i < HIST_N; i++) hist[i] = '0;
        last_busy = -1;
        if (cyc + 1 < HIST_N) hist[cyc + 1] = mk_alu(4, 1);
        @(posedge clk);
        #1;
        cyc += 2;
        step(din_t'('0), o);
        chk("post_rst_sel", o.sel, 0);
        chk("post_rst_busy", o.bz, 0);

        o = '0;
        cur = '0;
        for (int k = 0; k < 400; k++) begin
            if (!o.st) cur = rand_instr();
            step(cur, o);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
